// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, SP register index and
// the write-back FSM state encoding.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int HALF_W_DEF = 16;
   localparam int SEL_W_DEF  = 4;

   // Register-file index that aliases the stack pointer.
   localparam logic [SEL_W_DEF-1:0] SP_REG_IDX = 4'd13;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_LOAD_HI = 1'b1
   } wb_state_t;

endpackage

// File: rtl/load_assembler.sv
// Load assembler: holds the first returned halfword of a two-beat load and
// owns the write-data register. That register takes either the
// concatenated load word or the ALU result.
module load_assembler #(
   parameter int DATA_W   = 32,
   parameter int HALF_W   = 16,
   parameter int LO_FIRST = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alu_load_i,
   input  logic [DATA_W-1:0] alu_data_i,
   input  logic              cap_first_i,
   input  logic              cap_second_i,
   input  logic [HALF_W-1:0] rdata_i,
   output logic [DATA_W-1:0] data_o
);

   logic [HALF_W-1:0] first_q;

   // Order the two halfwords according to which one memory returns first.
   function automatic logic [DATA_W-1:0] assemble(input logic [HALF_W-1:0] first,
                                                  input logic [HALF_W-1:0] second);
      if (LO_FIRST != 0) return {second, first};
      else               return {first, second};
   endfunction

   // Capture the first half, then register the full word on the second beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         first_q <= '0;
         data_o  <= '0;
      end else begin
         if (cap_first_i) first_q <= rdata_i;
         if (cap_second_i)    data_o <= assemble(first_q, rdata_i);
         else if (alu_load_i) data_o <= alu_data_i;
      end
   end

endmodule

// File: rtl/mem_writeback.sv
// Write-back stage: commits ALU results in one cycle and two-beat halfword
// loads in two, driving single-cycle register-file and SP write strobes.
// The in-flight write is mirrored on the fwd_* outputs for forwarding.
module mem_writeback
   import cpu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int HALF_W   = HALF_W_DEF,
   parameter int SEL_W    = SEL_W_DEF,
   parameter int LO_FIRST = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_calc_i,
   input  logic              mem_to_reg_i,
   input  logic [SEL_W-1:0]  rf_wr_select_i,
   input  logic              rf_wr_en_i,
   input  logic              rf_sp_wr_en_i,
   input  logic [DATA_W-1:0] sp_i,
   input  logic [HALF_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] rf_wr_data_o,
   output logic [SEL_W-1:0]  rf_wr_select_o,
   output logic              rf_wr_en_o,
   output logic [DATA_W-1:0] rf_sp_data_o,
   output logic              rf_sp_wr_en_o,
   output logic              busy_o,
   output logic              fwd_valid_o,
   output logic [SEL_W-1:0]  fwd_sel_o,
   output logic [DATA_W-1:0] fwd_data_o
);

   wb_state_t        state;
   logic [SEL_W-1:0] sel_q;
   logic             wr_en_q;
   logic             sp_en_q;
   logic             alu_load;
   logic             cap_first;
   logic             cap_second;

   // Decode which beat the assembler sees this cycle.
   always_comb begin
      alu_load   = (state == ST_IDLE) && !mem_to_reg_i;
      cap_first  = (state == ST_IDLE) &&  mem_to_reg_i;
      cap_second = (state == ST_LOAD_HI);
   end

   load_assembler #(
      .DATA_W   (DATA_W),
      .HALF_W   (HALF_W),
      .LO_FIRST (LO_FIRST)
   ) u_load_asm (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .alu_load_i   (alu_load),
      .alu_data_i   (data_calc_i),
      .cap_first_i  (cap_first),
      .cap_second_i (cap_second),
      .rdata_i      (mem_rdata_i),
      .data_o       (rf_wr_data_o)
   );

   // FSM, load control latches and registered write-port outputs. During the
   // second load beat execute_mem repeats the load's controls, so only the
   // values latched on the first beat are used.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         busy_o         <= 1'b0;
         sel_q          <= '0;
         wr_en_q        <= 1'b0;
         sp_en_q        <= 1'b0;
         rf_wr_select_o <= '0;
         rf_wr_en_o     <= 1'b0;
         rf_sp_data_o   <= '0;
         rf_sp_wr_en_o  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_to_reg_i) begin
                  sel_q         <= rf_wr_select_i;
                  wr_en_q       <= rf_wr_en_i;
                  sp_en_q       <= rf_sp_wr_en_i;
                  rf_wr_en_o    <= 1'b0;
                  rf_sp_wr_en_o <= 1'b0;
                  busy_o        <= 1'b1;
                  state         <= ST_LOAD_HI;
               end else begin
                  rf_wr_select_o <= rf_wr_select_i;
                  rf_wr_en_o     <= rf_wr_en_i;
                  rf_sp_data_o   <= sp_i;
                  rf_sp_wr_en_o  <= rf_sp_wr_en_i;
               end
            end
            ST_LOAD_HI: begin
               rf_wr_select_o <= sel_q;
               rf_wr_en_o     <= wr_en_q;
               rf_sp_data_o   <= sp_i;
               rf_sp_wr_en_o  <= sp_en_q;
               busy_o         <= 1'b0;
               state          <= ST_IDLE;
            end
            default: begin
               rf_wr_en_o    <= 1'b0;
               rf_sp_wr_en_o <= 1'b0;
               busy_o        <= 1'b0;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

   // Forwarding mirrors the committed write.
   always_comb begin
      fwd_valid_o = rf_wr_en_o;
      fwd_sel_o   = rf_wr_select_o;
      fwd_data_o  = rf_wr_data_o;
   end

endmodule
